// File: rtl/hash_job_arbiter_pkg.sv
// hash_job_arbiter_pkg
//   Shared definitions for the hash job arbiter: field widths of the
//   nonce-search engine interface and the scheduler state encoding.
//   No ports (package).
package hash_job_arbiter_pkg;

  localparam int PAYLOAD_W = 96;
  localparam int TARGET_W  = 8;
  localparam int NONCE_W   = 32;
  localparam int HASH_W    = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/hash_job_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter: grants the first asserted request at
//   or after ptr, wrapping modulo NREQ. The pointer register lives outside.
// Ports:
//   req   in  NREQ           request vector
//   ptr   in  clog2(NREQ)    highest-priority index this cycle
//   grant out NREQ           one-hot grant, zero when no request
module rr_arbiter
  import hash_job_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  localparam int PW = $clog2(NREQ);
  // one extra bit so ptr + i cannot overflow before the modulo fold
  localparam logic [PW:0] NREQ_X = (PW+1)'(NREQ);

  logic [PW:0] pos;
  logic        found;

  // scan NREQ positions starting at ptr; first hit wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= NREQ_X) begin
        pos = pos - NREQ_X;
      end else begin
        pos = pos;
      end
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/hash_job_arbiter.sv
// hash_job_arbiter
//   Shares one nonce-search engine among NREQ requesters. One job at a time:
//   IDLE arbitrates round-robin and latches the job, RUN keeps the engine
//   active under a cycle watchdog, RESP presents the result to the owner
//   until it acknowledges.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready  NREQ  job request handshake (ready only in IDLE)
//   req_payload  96*NREQ       payload, requester i at [96i+95:96i]
//   req_target   8*NREQ        target, requester i at [8i+7:8i]
//   rsp_valid/rsp_ack    NREQ  result handshake, one-hot to owner
//   rsp_nonce/rsp_hash         result data (zero on timeout)
//   rsp_timeout                watchdog expired
//   eng_payload/eng_target/eng_active   to engine
//   eng_terminado/eng_nonce/eng_hash    from engine
module hash_job_arbiter
  import hash_job_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [PAYLOAD_W*NREQ-1:0] req_payload,
  input  logic [TARGET_W*NREQ-1:0]  req_target,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ack,
  output logic [NONCE_W-1:0]        rsp_nonce,
  output logic [HASH_W-1:0]         rsp_hash,
  output logic                      rsp_timeout,
  output logic [PAYLOAD_W-1:0]      eng_payload,
  output logic [TARGET_W-1:0]       eng_target,
  output logic                      eng_active,
  input  logic                      eng_terminado,
  input  logic [NONCE_W-1:0]        eng_nonce,
  input  logic [HASH_W-1:0]         eng_hash
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(NREQ - 1);

  state_t                 state_r, state_s;
  logic [PW-1:0]          rr_ptr_r, rr_ptr_s;
  logic [PW-1:0]          owner_r, owner_s;
  logic [WDW-1:0]         wd_r, wd_s;
  logic [NREQ-1:0]        grant_s;
  logic [PW-1:0]          grant_idx_s;
  logic [PAYLOAD_W-1:0]   payload_sel_s;
  logic [TARGET_W-1:0]    target_sel_s;
  logic [NREQ-1:0]        owner_oh_s;

  logic [PAYLOAD_W-1:0]   eng_payload_s;
  logic [TARGET_W-1:0]    eng_target_s;
  logic                   eng_active_s;
  logic [NREQ-1:0]        rsp_valid_s;
  logic [NONCE_W-1:0]     rsp_nonce_s;
  logic [HASH_W-1:0]      rsp_hash_s;
  logic                   rsp_timeout_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // encode the one-hot grant and mux the granted requester's job data
  always_comb begin
    grant_idx_s   = '0;
    payload_sel_s = '0;
    target_sel_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        grant_idx_s   = PW'(i);
        payload_sel_s = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        target_sel_s  = req_target[i*TARGET_W +: TARGET_W];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  assign owner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;

  // next-state and next-output logic for the job scheduler
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    owner_s       = owner_r;
    wd_s          = wd_r;
    eng_payload_s = eng_payload;
    eng_target_s  = eng_target;
    eng_active_s  = eng_active;
    rsp_valid_s   = rsp_valid;
    rsp_nonce_s   = rsp_nonce;
    rsp_hash_s    = rsp_hash;
    rsp_timeout_s = rsp_timeout;
    req_ready     = '0;
    case (state_r)
      ST_IDLE: begin
        req_ready = grant_s;
        // a grant always implies a transfer since ready mirrors the grant
        if (|grant_s) begin
          eng_payload_s = payload_sel_s;
          eng_target_s  = target_sel_s;
          owner_s       = grant_idx_s;
          wd_s          = '0;
          eng_active_s  = 1'b1;
          state_s       = ST_RUN;
        end else begin
          eng_active_s = 1'b0;
        end
      end
      ST_RUN: begin
        // terminado is checked first so it wins over a same-cycle expiry
        if (eng_terminado) begin
          rsp_nonce_s   = eng_nonce;
          rsp_hash_s    = eng_hash;
          rsp_timeout_s = 1'b0;
          rsp_valid_s   = owner_oh_s;
          eng_active_s  = 1'b0;
          state_s       = ST_RESP;
        end else if (wd_r == WD_LAST) begin
          rsp_nonce_s   = '0;
          rsp_hash_s    = '0;
          rsp_timeout_s = 1'b1;
          rsp_valid_s   = owner_oh_s;
          eng_active_s  = 1'b0;
          state_s       = ST_RESP;
        end else begin
          wd_s = wd_r + WDW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ack[owner_r]) begin
          rsp_valid_s = '0;
          if (owner_r == PTR_LAST) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = owner_r + PW'(1);
          end
          state_s = ST_IDLE;
        end else begin
          rsp_valid_s = rsp_valid;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        eng_active_s = 1'b0;
        rsp_valid_s  = '0;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      wd_r        <= '0;
      eng_payload <= '0;
      eng_target  <= '0;
      eng_active  <= 1'b0;
      rsp_valid   <= '0;
      rsp_nonce   <= '0;
      rsp_hash    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      owner_r     <= owner_s;
      wd_r        <= wd_s;
      eng_payload <= eng_payload_s;
      eng_target  <= eng_target_s;
      eng_active  <= eng_active_s;
      rsp_valid   <= rsp_valid_s;
      rsp_nonce   <= rsp_nonce_s;
      rsp_hash    <= rsp_hash_s;
      rsp_timeout <= rsp_timeout_s;
    end
  end

endmodule

// File: tb/tb_hash_job_arbiter.sv
// Testbench for hash_job_arbiter: a long-timeout instance and a TIMEOUT=16
// instance share stimulus; sel picks which one is observed and checked.
module tb_hash_job_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   rsp_ack;
  logic [383:0] req_payload;
  logic [31:0]  req_target;
  logic [31:0]  eng_nonce;
  logic [23:0]  eng_hash;
  int           term_at;
  logic         sel;

  logic [3:0]  l_req_ready, s_req_ready, l_rsp_valid, s_rsp_valid;
  logic [31:0] l_rsp_nonce, s_rsp_nonce;
  logic [23:0] l_rsp_hash, s_rsp_hash;
  logic        l_rsp_timeout, s_rsp_timeout;
  logic [95:0] l_eng_payload, s_eng_payload;
  logic [7:0]  l_eng_target, s_eng_target;
  logic        l_eng_active, s_eng_active;
  logic        l_term, s_term;
  int          l_cnt, s_cnt;

  always #5 clk = ~clk;

  hash_job_arbiter #(.NREQ(4)) u_long (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(l_req_ready),
    .req_payload(req_payload), .req_target(req_target), .rsp_valid(l_rsp_valid),
    .rsp_ack(rsp_ack), .rsp_nonce(l_rsp_nonce), .rsp_hash(l_rsp_hash),
    .rsp_timeout(l_rsp_timeout), .eng_payload(l_eng_payload), .eng_target(l_eng_target),
    .eng_active(l_eng_active), .eng_terminado(l_term), .eng_nonce(eng_nonce),
    .eng_hash(eng_hash)
  );

  hash_job_arbiter #(.NREQ(4), .TIMEOUT(16)) u_short (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_payload(req_payload), .req_target(req_target), .rsp_valid(s_rsp_valid),
    .rsp_ack(rsp_ack), .rsp_nonce(s_rsp_nonce), .rsp_hash(s_rsp_hash),
    .rsp_timeout(s_rsp_timeout), .eng_payload(s_eng_payload), .eng_target(s_eng_target),
    .eng_active(s_eng_active), .eng_terminado(s_term), .eng_nonce(eng_nonce),
    .eng_hash(eng_hash)
  );

  // engine stubs: terminado during active cycle number term_at (0 = never)
  always_ff @(posedge clk) l_cnt <= l_eng_active ? l_cnt + 1 : 0;
  always_ff @(posedge clk) s_cnt <= s_eng_active ? s_cnt + 1 : 0;
  assign l_term = l_eng_active && (term_at != 0) && (l_cnt == term_at - 1);
  assign s_term = s_eng_active && (term_at != 0) && (s_cnt == term_at - 1);

  logic [3:0]  v_req_ready, v_rsp_valid;
  logic [31:0] v_rsp_nonce;
  logic [23:0] v_rsp_hash;
  logic        v_rsp_timeout, v_eng_active;
  logic [95:0] v_eng_payload;
  logic [7:0]  v_eng_target;
  assign v_req_ready   = sel ? s_req_ready   : l_req_ready;
  assign v_rsp_valid   = sel ? s_rsp_valid   : l_rsp_valid;
  assign v_rsp_nonce   = sel ? s_rsp_nonce   : l_rsp_nonce;
  assign v_rsp_hash    = sel ? s_rsp_hash    : l_rsp_hash;
  assign v_rsp_timeout = sel ? s_rsp_timeout : l_rsp_timeout;
  assign v_eng_active  = sel ? s_eng_active  : l_eng_active;
  assign v_eng_payload = sel ? s_eng_payload : l_eng_payload;
  assign v_eng_target  = sel ? s_eng_target  : l_eng_target;

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] n;
    logic [23:0] h;
    logic        to;
    int          len;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        rst_first;
    logic        sel;
    logic [3:0]  mask;
    int          owner;
    int          term;
    logic [31:0] n;
    logic [23:0] h;
    logic        to;
    int          len;
    logic [95:0] pbase;
    logic [7:0]  tbase;
  } vec_t;
  vec_t tbl[10];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic new_sel);
    rst_n     = 1'b0;
    sel       = new_sel;
    req_valid = 4'b0000;
    rsp_ack   = 4'b0000;
    cycle();
    cycle();
    rst_n = 1'b1;
    q.delete();
  endtask

  // response monitor: active-run length, inter-job gap, scoreboard compare
  initial begin
    int    run_len = 0, last_len = 0, idle_cnt = 0;
    logic  prev_act = 1'b0, seen_fall = 1'b0;
    logic [3:0] prev_v = 4'b0000;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0; idle_cnt = 0; prev_act = 1'b0; seen_fall = 1'b0;
        prev_v = v_rsp_valid;
      end else begin
        if (v_eng_active) begin
          if (!prev_act && seen_fall) chk("idle_gap_ge2", 128'(idle_cnt >= 2), 128'(1));
          run_len++;
          idle_cnt = 0;
        end else begin
          if (prev_act) begin
            last_len = run_len; run_len = 0; seen_fall = 1'b1;
          end
          idle_cnt++;
        end
        prev_act = v_eng_active;
        if (v_rsp_valid != 4'b0000 && prev_v == 4'b0000) begin
          chk("rsp_expected", 128'(q.size() != 0), 128'(1));
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_valid_owner", v_rsp_valid, e.oh);
            chk("rsp_nonce", v_rsp_nonce, e.n);
            chk("rsp_hash", v_rsp_hash, e.h);
            chk("rsp_timeout", v_rsp_timeout, e.to);
            chk("active_len", 128'(last_len), 128'(e.len));
          end
        end
        prev_v = v_rsp_valid;
      end
    end
  end

  task automatic run_job(input logic [3:0] mask, input int owner, input int term,
                         input logic [31:0] n, input logic [23:0] h, input logic to,
                         input int len, input logic [95:0] pbase, input logic [7:0] tbase,
                         input logic do_ack);
    logic [3:0] oh;
    logic       busy;
    int         k;
    exp_t       e;
    oh = 4'b0001 << owner;
    req_valid = mask;
    for (int r = 0; r < 4; r++) begin
      req_payload[r*96 +: 96] = pbase + 96'(r);
      req_target[r*8 +: 8]    = tbase + 8'(r);
    end
    term_at   = term;
    eng_nonce = n;
    eng_hash  = h;
    #1;
    chk("grant", v_req_ready, oh);
    e.oh = oh; e.n = to ? 32'h0 : n; e.h = to ? 24'h0 : h; e.to = to; e.len = len;
    q.push_back(e);
    cycle();
    chk("active_on_accept", v_eng_active, 1'b1);
    chk("eng_payload", v_eng_payload, pbase + 96'(owner));
    chk("eng_target", v_eng_target, tbase + 8'(owner));
    // disturb requester inputs while the job runs
    req_payload = ~req_payload;
    req_target  = ~req_target;
    req_valid   = 4'b1111;
    busy = 1'b0;
    k = 0;
    while (v_rsp_valid == 4'b0000 && k < 200) begin
      if (v_req_ready != 4'b0000) busy = 1'b1;
      cycle();
      k++;
    end
    chk("rsp_arrived", 128'(v_rsp_valid != 4'b0000), 128'(1));
    chk("ready_low_busy", busy, 1'b0);
    chk("payload_held", v_eng_payload, pbase + 96'(owner));
    chk("target_held", v_eng_target, tbase + 8'(owner));
    if (do_ack) begin
      rsp_ack = oh;
      cycle();
      rsp_ack   = 4'b0000;
      req_valid = 4'b0000;
      chk("rsp_clear_after_ack", v_rsp_valid, 4'b0000);
    end else begin
      req_valid = 4'b0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] snap_n;
    logic [23:0] snap_h;
    logic        stable, rdy;

    rst_n = 1'b0; sel = 1'b0; req_valid = 4'b0000; rsp_ack = 4'b0000;
    req_payload = '0; req_target = '0; eng_nonce = '0; eng_hash = '0; term_at = 0;

    // single job, round-robin order 0,1,3,0 then wrap cases, timeout, collision
    tbl[0] = '{1'b1, 1'b0, 4'b0001, 0, 37, 32'h0000_0025, 24'h03ABCD, 1'b0, 37,
               96'h397d9f2f40ca9e6c6b1f3324, 8'd10};
    tbl[1] = '{1'b1, 1'b0, 4'b1011, 0, 5, 32'h1111_0001, 24'h000011, 1'b0, 5, 96'hA0, 8'h20};
    tbl[2] = '{1'b0, 1'b0, 4'b1011, 1, 5, 32'h1111_0002, 24'h000022, 1'b0, 5, 96'hB0, 8'h30};
    tbl[3] = '{1'b0, 1'b0, 4'b1011, 3, 5, 32'h1111_0003, 24'h000033, 1'b0, 5, 96'hC0, 8'h40};
    tbl[4] = '{1'b0, 1'b0, 4'b1011, 0, 5, 32'h1111_0004, 24'h000044, 1'b0, 5, 96'hD0, 8'h50};
    tbl[5] = '{1'b0, 1'b0, 4'b0110, 1, 3, 32'h1111_0005, 24'h000055, 1'b0, 3, 96'hE0, 8'h60};
    tbl[6] = '{1'b0, 1'b0, 4'b0101, 2, 1, 32'h1111_0006, 24'h000066, 1'b0, 1, 96'hF0, 8'h70};
    tbl[7] = '{1'b0, 1'b0, 4'b1000, 3, 7, 32'h1111_0007, 24'h000077, 1'b0, 7, 96'h100, 8'h80};
    tbl[8] = '{1'b1, 1'b1, 4'b0100, 2, 0, 32'hDEAD_BEEF, 24'hBEEF00, 1'b1, 16, 96'h200, 8'h90};
    tbl[9] = '{1'b1, 1'b1, 4'b0100, 2, 16, 32'h0BAD_F00D, 24'h123456, 1'b0, 16, 96'h300, 8'hA0};

    do_reset(1'b0);
    chk("reset_eng_active", v_eng_active, 1'b0);
    chk("reset_eng_payload", v_eng_payload, 96'h0);
    chk("reset_eng_target", v_eng_target, 8'h0);
    chk("reset_rsp_valid", v_rsp_valid, 4'b0000);
    chk("reset_rsp_nonce", v_rsp_nonce, 32'h0);
    chk("reset_rsp_hash", v_rsp_hash, 24'h0);
    chk("reset_rsp_timeout", v_rsp_timeout, 1'b0);
    chk("reset_req_ready", v_req_ready, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_first) do_reset(tbl[i].sel);
      run_job(tbl[i].mask, tbl[i].owner, tbl[i].term, tbl[i].n, tbl[i].h, tbl[i].to,
              tbl[i].len, tbl[i].pbase, tbl[i].tbase, 1'b1);
    end

    // backpressure: owner 1 holds its result, non-owner ack pulsed
    do_reset(1'b0);
    run_job(4'b0010, 1, 5, 32'hCAFE_0001, 24'h5A5A5A, 1'b0, 5, 96'h400, 8'hB0, 1'b0);
    snap_n = v_rsp_nonce;
    snap_h = v_rsp_hash;
    stable = 1'b1;
    rdy    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rsp_ack   = (k == 5) ? 4'b0100 : 4'b0000;
      req_valid = 4'b1111;
      cycle();
      if (v_rsp_valid != 4'b0010 || v_rsp_nonce != snap_n || v_rsp_hash != snap_h) stable = 1'b0;
      if (v_req_ready != 4'b0000) rdy = 1'b1;
    end
    rsp_ack = 4'b0000;
    chk("bp_stable", stable, 1'b1);
    chk("bp_no_ready", rdy, 1'b0);
    chk("bp_nonce_value", snap_n, 32'hCAFE_0001);
    rsp_ack = 4'b0010;
    req_valid = 4'b0000;
    cycle();
    rsp_ack = 4'b0000;
    chk("bp_cleared", v_rsp_valid, 4'b0000);

    // reset mid-RUN: pointer is 2, so requester 3 wins first
    req_valid = 4'b1010;
    term_at   = 0;
    #1;
    chk("mid_grant_ptr2", v_req_ready, 4'b1000);
    cycle();
    for (int k = 0; k < 9; k++) cycle();
    chk("mid_active_c10", v_eng_active, 1'b1);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_active", v_eng_active, 1'b0);
    chk("mid_rst_payload", v_eng_payload, 96'h0);
    chk("mid_rst_target", v_eng_target, 8'h0);
    chk("mid_rst_rsp_valid", v_rsp_valid, 4'b0000);
    chk("mid_rst_nonce", v_rsp_nonce, 32'h0);
    chk("mid_rst_hash", v_rsp_hash, 24'h0);
    chk("mid_rst_timeout", v_rsp_timeout, 1'b0);
    chk("mid_rst_ready", v_req_ready, 4'b0000);
    run_job(4'b1010, 1, 5, 32'h7777_0001, 24'h777777, 1'b0, 5, 96'h500, 8'hC0, 1'b1);

    repeat (4) cycle();
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
